// File: rtl/vscale_lsu_constants.sv
// vscale_lsu_constants: memory-type encodings shared with ctrl, response-entry
// layout, and the lane mask / store replicate / load extract helpers.
// Helpers work on a 64-bit lane set; callers truncate to XLEN.
package vscale_lsu_constants;

   localparam int unsigned MEM_TYPE_WIDTH  = 3;
   localparam int unsigned RD_WIDTH        = 5;
   localparam int unsigned RESP_META_WIDTH = RD_WIDTH + 3;

   // Bits [1:0] give the access size, bit 2 selects zero-extension.
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB  = 3'd0;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = 3'd1;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = 3'd2;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LD  = 3'd3;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LBU = 3'd4;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = 3'd5;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LWU = 3'd6;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB  = MEM_TYPE_LB;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH  = MEM_TYPE_LH;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW  = MEM_TYPE_LW;
   localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SD  = MEM_TYPE_LD;

   // Per-entry metadata stored alongside the response data.
   typedef struct packed {
      logic [RD_WIDTH-1:0] rd;
      logic                wen;
      logic                fault;
      logic                mis;
   } resp_meta_t;

   // Byte-lane enables for a size at a byte offset; upper lanes drop on truncation.
   function automatic logic [7:0] lsu_bmask(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   // Replicate the LSB-aligned store datum across every lane of the bus.
   function automatic logic [63:0] lsu_replicate(input logic [1:0] size, input logic [63:0] d);
      logic [63:0] r;
      case (size)
         2'd0:    r = {8{d[7:0]}};
         2'd1:    r = {4{d[15:0]}};
         2'd2:    r = {2{d[31:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   // Shift the addressed bytes down and sign/zero-extend by access type.
   function automatic logic [63:0] lsu_extract(input logic [2:0] mem_type, input logic [2:0] off,
                                               input logic [63:0] d);
      logic [63:0] sh;
      logic        sx;
      logic [63:0] r;
      sh = d >> {off, 3'b000};
      sx = ~mem_type[2];
      case (mem_type[1:0])
         2'd0:    r = {{56{sx & sh[7]}},  sh[7:0]};
         2'd1:    r = {{48{sx & sh[15]}}, sh[15:0]};
         2'd2:    r = {{32{sx & sh[31]}}, sh[31:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vscale_lsu_resp_fifo.sv
// vscale_lsu_resp_fifo: DEPTH x WIDTH synchronous FIFO with occupancy count
// and asynchronous active-high reset. Pushing when full or popping when empty
// is the caller's responsibility to avoid.
module vscale_lsu_resp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/vscale_lsu_pipe.sv
// vscale_lsu_pipe: load/store unit between execute and the two-phase data-memory
// port. Address phase is combinational from the request; a data-phase register
// tracks the access until dmem_wait drops, then the result enters a response FIFO.
// Optional feature: define VSCALE_LSU_MISALIGN_EN to trap misaligned H/W/D accesses.
module vscale_lsu_pipe
   import vscale_lsu_constants::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wen,
   input  logic [MEM_TYPE_WIDTH-1:0] req_type,
   input  logic [XLEN-1:0]           req_addr,
   input  logic [XLEN-1:0]           req_wdata,
   input  logic [4:0]                req_rd,
   output logic                      dmem_en,
   output logic                      dmem_wen,
   output logic [MEM_TYPE_WIDTH-1:0] dmem_size,
   output logic [XLEN-1:0]           dmem_addr,
   output logic [XLEN/8-1:0]         dmem_bmask,
   output logic [XLEN-1:0]           dmem_wdata,
   input  logic                      dmem_wait,
   input  logic [XLEN-1:0]           dmem_rdata,
   input  logic                      dmem_badmem_e,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [XLEN-1:0]           resp_data,
   output logic [4:0]                resp_rd,
   output logic                      resp_wen,
   output logic                      resp_fault,
   output logic                      resp_misaligned
);

   localparam int unsigned NBYTES  = XLEN / 8;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = XLEN + RESP_META_WIDTH;
   localparam logic [2:0]  OFF_MASK = 3'(NBYTES - 1);

   logic                      dp_valid;
   logic                      dp_wen;
   logic [MEM_TYPE_WIDTH-1:0] dp_type;
   logic [2:0]                dp_off;
   logic [4:0]                dp_rd;
   logic [XLEN-1:0]           dp_wdata;
   logic                      dp_mis;

   logic                      mis_c;
   logic                      dp_stall_c;
   logic                      accept_c;
   logic [OCC_W-1:0]          occ_c;
   logic [2:0]                off_c;
   logic [XLEN-1:0]           load_c;
   logic                      push_c;
   logic                      pop_c;
   resp_meta_t                push_meta_c;
   logic [ENTRY_W-1:0]        push_entry_c;
   logic [ENTRY_W-1:0]        head_entry;
   resp_meta_t                head_meta;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CNT_W-1:0]          fifo_count;

`ifdef VSCALE_LSU_MISALIGN_EN
   // Flag halfword/word/doubleword requests not aligned to their size.
   always_comb begin
      mis_c = 1'b0;
      case (req_type[1:0])
         2'd1:    mis_c = req_addr[0];
         2'd2:    mis_c = |req_addr[1:0];
         2'd3:    mis_c = |req_addr[2:0];
         default: mis_c = 1'b0;
      endcase
   end
`else
   assign mis_c = 1'b0;
`endif

   // Accept only when the bus is not stalling and the FIFO can hold every in-flight result.
   assign dp_stall_c = dp_valid && !dp_mis && dmem_wait;
   assign occ_c      = OCC_W'(fifo_count) + OCC_W'(dp_valid);
   assign req_ready  = !reset && !dp_stall_c && !fifo_full && (occ_c < OCC_W'(DEPTH));
   assign accept_c   = req_valid && req_ready;

   assign dmem_en    = accept_c && !mis_c;
   assign dmem_wen   = req_wen;
   assign dmem_size  = req_type;
   assign dmem_addr  = req_addr;

   // Data-phase register: holds while the bus stalls, otherwise loads the next accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_valid <= 1'b0;
         dp_wen   <= 1'b0;
         dp_type  <= '0;
         dp_off   <= '0;
         dp_rd    <= '0;
         dp_wdata <= '0;
         dp_mis   <= 1'b0;
      end else if (!dp_stall_c) begin
         dp_valid <= accept_c;
         if (accept_c) begin
            dp_wen   <= req_wen;
            dp_type  <= req_type;
            dp_off   <= req_addr[2:0];
            dp_rd    <= req_rd;
            dp_wdata <= req_wdata;
            dp_mis   <= mis_c;
         end
      end
   end

   // Data-phase lane mask, replicated store data and extended load data.
   assign off_c      = dp_off & OFF_MASK;
   assign dmem_bmask = (dp_valid && !dp_mis) ? NBYTES'(lsu_bmask(dp_type[1:0], off_c)) : '0;
   assign dmem_wdata = XLEN'(lsu_replicate(dp_type[1:0], 64'(dp_wdata)));
   assign load_c     = XLEN'(lsu_extract(dp_type, off_c, 64'(dmem_rdata)));

   // Completion: bus accesses finish when wait drops, trapped ones finish immediately.
   assign push_c             = dp_valid && (dp_mis || !dmem_wait);
   assign push_meta_c.rd     = dp_rd;
   assign push_meta_c.wen    = dp_wen;
   assign push_meta_c.fault  = !dp_mis && dmem_badmem_e;
   assign push_meta_c.mis    = dp_mis;
   assign push_entry_c       = {(dp_wen || dp_mis) ? '0 : load_c, push_meta_c};
   assign pop_c              = resp_valid && resp_ready;

   vscale_lsu_resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_resp_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (push_entry_c),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_meta       = resp_meta_t'(head_entry[RESP_META_WIDTH-1:0]);
   assign resp_valid      = !fifo_empty;
   assign resp_data       = head_entry[ENTRY_W-1:RESP_META_WIDTH];
   assign resp_rd         = head_meta.rd;
   assign resp_wen        = head_meta.wen;
   assign resp_fault      = head_meta.fault;
   assign resp_misaligned = head_meta.mis;

endmodule

// File: tb/tb_vscale_lsu_pipe.sv
// tb_vscale_lsu_pipe: directed checks of vscale_lsu_pipe at XLEN=32 and XLEN=64.
module tb_vscale_lsu_pipe;
   import vscale_lsu_constants::*;

`ifdef VSCALE_LSU_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;

   // XLEN=32 instance
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_type;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        dmem_en, dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_bmask;
   logic        dmem_wait, dmem_badmem_e;
   logic        resp_valid, resp_ready, resp_wen, resp_fault, resp_misaligned;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;

   // XLEN=64 instance
   logic        w_req_valid, w_req_ready, w_req_wen;
   logic [2:0]  w_req_type;
   logic [63:0] w_req_addr, w_req_wdata;
   logic [4:0]  w_req_rd;
   logic        w_dmem_en, w_dmem_wen;
   logic [2:0]  w_dmem_size;
   logic [63:0] w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
   logic [7:0]  w_dmem_bmask;
   logic        w_dmem_wait, w_dmem_badmem_e;
   logic        w_resp_valid, w_resp_ready, w_resp_wen, w_resp_fault, w_resp_misaligned;
   logic [63:0] w_resp_data;
   logic [4:0]  w_resp_rd;

   int checks = 0;
   int errors = 0;

   vscale_lsu_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
      .dmem_bmask(dmem_bmask), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
      .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_wen(resp_wen), .resp_fault(resp_fault), .resp_misaligned(resp_misaligned)
   );

   vscale_lsu_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(w_req_valid), .req_ready(w_req_ready), .req_wen(w_req_wen), .req_type(w_req_type),
      .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_rd(w_req_rd),
      .dmem_en(w_dmem_en), .dmem_wen(w_dmem_wen), .dmem_size(w_dmem_size), .dmem_addr(w_dmem_addr),
      .dmem_bmask(w_dmem_bmask), .dmem_wdata(w_dmem_wdata), .dmem_wait(w_dmem_wait),
      .dmem_rdata(w_dmem_rdata), .dmem_badmem_e(w_dmem_badmem_e),
      .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_data(w_resp_data),
      .resp_rd(w_resp_rd), .resp_wen(w_resp_wen), .resp_fault(w_resp_fault),
      .resp_misaligned(w_resp_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  typ;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_bmask;
      logic [31:0] exp_wdata;
      logic [31:0] exp_resp;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic drive32(input logic [2:0] t, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
      req_valid = 1'b1;
      req_type  = t;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
   endtask

   // One no-wait access on the 64-bit instance: check mask, store data and response.
   task automatic run64(input string name, input logic [2:0] t, input logic wen,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [7:0] exp_bmask, input logic [63:0] exp_wdata,
                        input logic [63:0] exp_resp);
      tick();
      w_req_valid = 1'b1; w_req_type = t; w_req_wen = wen;
      w_req_addr = addr; w_req_wdata = wdata; w_req_rd = 5'd17;
      samp();
      chk({name, "_en"}, w_dmem_en, 1'b1);
      tick();
      w_req_valid = 1'b0;
      w_dmem_rdata = rdata;
      samp();
      chk({name, "_bmask"}, w_dmem_bmask, exp_bmask);
      if (wen) chk({name, "_wdata"}, w_dmem_wdata, exp_wdata);
      tick();
      samp();
      chk({name, "_valid"}, w_resp_valid, 1'b1);
      chk({name, "_data"}, w_resp_data, exp_resp);
      chk({name, "_wen"}, w_resp_wen, wen);
      chk({name, "_rd"}, w_resp_rd, 5'd17);
   endtask

   initial begin
      vecs[0] = '{MEM_TYPE_LB,  1'b0, 32'h1003, 32'h0, 32'h80FF_FF00, 4'h8, 32'h0, 32'hFFFF_FF80};
      vecs[1] = '{MEM_TYPE_LBU, 1'b0, 32'h1003, 32'h0, 32'h80FF_FF00, 4'h8, 32'h0, 32'h0000_0080};
      vecs[2] = '{MEM_TYPE_LH,  1'b0, 32'h1002, 32'h0, 32'h8001_0000, 4'hC, 32'h0, 32'hFFFF_8001};
      vecs[3] = '{MEM_TYPE_LHU, 1'b0, 32'h1000, 32'h0, 32'h1234_F00D, 4'h3, 32'h0, 32'h0000_F00D};
      vecs[4] = '{MEM_TYPE_LW,  1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF};
      vecs[5] = '{MEM_TYPE_LWU, 1'b0, 32'h1008, 32'h0, 32'h8000_0001, 4'hF, 32'h0, 32'h8000_0001};
      vecs[6] = '{MEM_TYPE_SB,  1'b1, 32'h1001, 32'hFFFF_FFA5, 32'h0, 4'h2, 32'hA5A5_A5A5, 32'h0};
      vecs[7] = '{MEM_TYPE_SH,  1'b1, 32'h1002, 32'h1111_BEEF, 32'h0, 4'hC, 32'hBEEF_BEEF, 32'h0};
      vecs[8] = '{MEM_TYPE_SW,  1'b1, 32'h1000, 32'h1234_5678, 32'h0, 4'hF, 32'h1234_5678, 32'h0};

      reset = 1'b1;
      req_valid = 1'b1; req_wen = 1'b0; req_type = MEM_TYPE_LW; req_addr = 32'h1000;
      req_wdata = '0; req_rd = '0;
      dmem_wait = 1'b0; dmem_rdata = '0; dmem_badmem_e = 1'b0; resp_ready = 1'b1;
      w_req_valid = 1'b1; w_req_wen = 1'b0; w_req_type = MEM_TYPE_LD; w_req_addr = 64'h1000;
      w_req_wdata = '0; w_req_rd = '0;
      w_dmem_wait = 1'b0; w_dmem_rdata = '0; w_dmem_badmem_e = 1'b0; w_resp_ready = 1'b1;

      // Reset state
      repeat (2) samp();
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_dmem_en", dmem_en, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_w_dmem_en", w_dmem_en, 1'b0);
      tick();
      reset = 1'b0;
      req_valid = 1'b0;
      w_req_valid = 1'b0;
      samp();
      chk("post_rst_ready", req_ready, 1'b1);
      chk("post_rst_resp_valid", resp_valid, 1'b0);

      // Table of single no-wait accesses at XLEN=32
      for (int i = 0; i < NVEC; i++) begin
         tick();
         drive32(vecs[i].typ, vecs[i].wen, vecs[i].addr, vecs[i].wdata, 5'(i + 1));
         samp();
         chk("vec_ready", req_ready, 1'b1);
         chk("vec_en", dmem_en, 1'b1);
         chk("vec_size", dmem_size, vecs[i].typ);
         chk("vec_addr", dmem_addr, vecs[i].addr);
         chk("vec_wen", dmem_wen, vecs[i].wen);
         tick();
         req_valid = 1'b0;
         dmem_rdata = vecs[i].rdata;
         samp();
         chk("vec_bmask", dmem_bmask, vecs[i].exp_bmask);
         if (vecs[i].wen) chk("vec_wdata", dmem_wdata, vecs[i].exp_wdata);
         chk("vec_no_early_resp", resp_valid, 1'b0);
         tick();
         samp();
         chk("vec_resp_valid", resp_valid, 1'b1);
         chk("vec_resp_data", resp_data, vecs[i].exp_resp);
         chk("vec_resp_wen", resp_wen, vecs[i].wen);
         chk("vec_resp_rd", resp_rd, 5'(i + 1));
         chk("vec_resp_fault", resp_fault, 1'b0);
      end

      // XLEN=64 accesses
      run64("w_sh", MEM_TYPE_SH, 1'b1, 64'h0000_0000_0000_1006, 64'h0000_0000_0000_BEEF, 64'h0,
            8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0);
      run64("w_lw", MEM_TYPE_LW, 1'b0, 64'h0000_0000_0000_2004, 64'h0, 64'h8000_0000_0000_0000,
            8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000);
      run64("w_lwu", MEM_TYPE_LWU, 1'b0, 64'h0000_0000_0000_2004, 64'h0, 64'h8000_0000_0000_0000,
            8'hF0, 64'h0, 64'h0000_0000_8000_0000);
      run64("w_ld", MEM_TYPE_LD, 1'b0, 64'h0000_0000_0000_2008, 64'h0, 64'h0123_4567_89AB_CDEF,
            8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);
      run64("w_sb", MEM_TYPE_SB, 1'b1, 64'h0000_0000_0000_3005, 64'h0000_0000_0000_003C, 64'h0,
            8'h20, 64'h3C3C_3C3C_3C3C_3C3C, 64'h0);
      tick();

      // Wait-state stall: three wait cycles, next request accepted when wait drops
      drive32(MEM_TYPE_LW, 1'b0, 32'h1000, 32'h0, 5'd5);
      samp();
      chk("wait_acc_a", req_ready, 1'b1);
      tick();
      req_addr = 32'h2000; req_rd = 5'd6; dmem_wait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) tick();
         samp();
         chk("wait_stall_ready", req_ready, 1'b0);
         chk("wait_stall_en", dmem_en, 1'b0);
         chk("wait_no_resp", resp_valid, 1'b0);
      end
      tick();
      dmem_wait = 1'b0; dmem_rdata = 32'h1122_3344;
      samp();
      chk("wait_ready_back", req_ready, 1'b1);
      chk("wait_en_b", dmem_en, 1'b1);
      chk("wait_no_resp_yet", resp_valid, 1'b0);
      tick();
      req_valid = 1'b0; dmem_rdata = 32'h5566_7788;
      samp();
      chk("wait_resp_valid", resp_valid, 1'b1);
      chk("wait_resp_a_data", resp_data, 32'h1122_3344);
      chk("wait_resp_a_rd", resp_rd, 5'd5);
      tick();
      samp();
      chk("wait_resp_b_data", resp_data, 32'h5566_7788);
      chk("wait_resp_b_rd", resp_rd, 5'd6);
      tick();
      samp();
      chk("wait_drained", resp_valid, 1'b0);

      // FIFO full back-pressure with DEPTH=2 and ordering of tags
      resp_ready = 1'b0;
      tick();
      drive32(MEM_TYPE_LW, 1'b0, 32'h3000, 32'h0, 5'd1);
      samp();
      chk("full_acc_a", req_ready, 1'b1);
      tick();
      req_addr = 32'h3004; req_rd = 5'd2; dmem_rdata = 32'hA0A0_A0A0;
      samp();
      chk("full_acc_b", req_ready, 1'b1);
      tick();
      req_addr = 32'h3008; req_rd = 5'd3; dmem_rdata = 32'hB0B0_B0B0;
      samp();
      chk("full_hold_c0", req_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         samp();
         chk("full_hold_c", req_ready, 1'b0);
      end
      chk("full_head_a_rd", resp_rd, 5'd1);
      chk("full_head_a_data", resp_data, 32'hA0A0_A0A0);
      tick();
      resp_ready = 1'b1;
      samp();
      chk("full_hold_popping", req_ready, 1'b0);
      tick();
      resp_ready = 1'b0;
      samp();
      chk("full_ready_after_pop", req_ready, 1'b1);
      chk("full_head_b_rd", resp_rd, 5'd2);
      chk("full_head_b_data", resp_data, 32'hB0B0_B0B0);
      tick();
      req_valid = 1'b0; dmem_rdata = 32'hC0C0_C0C0;
      samp();
      tick();
      resp_ready = 1'b1;
      samp();
      chk("full_head_b_again", resp_rd, 5'd2);
      tick();
      samp();
      chk("full_head_c_rd", resp_rd, 5'd3);
      chk("full_head_c_data", resp_data, 32'hC0C0_C0C0);
      tick();
      samp();
      chk("full_drained", resp_valid, 1'b0);

      // Misaligned word
      tick();
      drive32(MEM_TYPE_LW, 1'b0, 32'h1002, 32'h0, 5'd8);
      samp();
      chk("mis_dmem_en", dmem_en, !MIS_EN);
      tick();
      req_valid = 1'b0; dmem_rdata = 32'hAABB_CCDD;
      samp();
      chk("mis_bmask", dmem_bmask, MIS_EN ? 4'h0 : 4'hC);
      tick();
      samp();
      chk("mis_resp_valid", resp_valid, 1'b1);
      chk("mis_resp_flag", resp_misaligned, MIS_EN);
      chk("mis_resp_fault", resp_fault, 1'b0);
      chk("mis_resp_data", resp_data, MIS_EN ? 32'h0 : 32'h0000_AABB);
      chk("mis_resp_rd", resp_rd, 5'd8);

      // Bus error at data-phase end
      tick();
      drive32(MEM_TYPE_LW, 1'b0, 32'h1000, 32'h0, 5'd7);
      samp();
      tick();
      req_valid = 1'b0; dmem_badmem_e = 1'b1; dmem_rdata = 32'h0;
      samp();
      tick();
      dmem_badmem_e = 1'b0;
      samp();
      chk("fault_resp_valid", resp_valid, 1'b1);
      chk("fault_resp_fault", resp_fault, 1'b1);
      chk("fault_resp_rd", resp_rd, 5'd7);
      chk("fault_resp_mis", resp_misaligned, 1'b0);

      // Reset pulse in the middle of a wait-stalled data phase
      tick();
      drive32(MEM_TYPE_LW, 1'b0, 32'h1000, 32'h0, 5'd9);
      samp();
      tick();
      req_valid = 1'b0; dmem_wait = 1'b1;
      samp();
      chk("rstw_stall", req_ready, 1'b0);
      tick();
      #2;
      reset = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("rstw_ready", req_ready, 1'b0);
      chk("rstw_en", dmem_en, 1'b0);
      chk("rstw_resp_valid", resp_valid, 1'b0);
      tick();
      reset = 1'b0; req_valid = 1'b0; dmem_wait = 1'b0;
      for (int k = 0; k < 4; k++) begin
         samp();
         chk("rstw_no_resp", resp_valid, 1'b0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
